// File: rtl/logic_unit_pkg.sv
// Shared types for the logic-unit arbiter: the 3-bit opcode set and the FSM states.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_NOTA = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise datapath: one opcode applied across W bits, illegal opcode flagged.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] data,
  output logic         err
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (op_e'(op))
      OP_AND:  data = a & b;
      OP_NAND: data = ~(a & b);
      OP_OR:   data = a | b;
      OP_NOR:  data = ~(a | b);
      OP_NOTA: data = ~a;
      OP_XOR:  data = a ^ b;
      OP_XNOR: data = ~(a ^ b);
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter feeding one shared bitwise logic unit (IDLE -> EXEC -> RESP).
// Define LOGIC_ARB_CNT_EN to add per-requester saturating grant counters on gnt_cnt.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [3*NREQ-1:0]        op,
  input  logic [W*NREQ-1:0]        a,
  input  logic [W*NREQ-1:0]        b,
  output logic [NREQ-1:0]          gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_data,
  output logic                     rsp_err
`ifdef LOGIC_ARB_CNT_EN
  ,
  output logic [CNT_W*NREQ-1:0]    gnt_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);

  state_e          r_state, w_next;
  logic [IDW-1:0]  r_ptr, r_win, w_win;
  logic            w_any;
  int              w_idx;
  logic [NREQ-1:0] r_gnt, w_onehot;
  logic [2:0]      r_op, w_sel_op;
  logic [W-1:0]    r_a, r_b, w_sel_a, w_sel_b;
  logic [W-1:0]    w_data;
  logic            w_err;

  // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_any && req[w_idx[IDW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_win) begin
        w_onehot[i] = 1'b1;
        w_sel_op    = op[3*i +: 3];
        w_sel_a     = a[W*i +: W];
        w_sel_b     = b[W*i +: W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_win    <= '0;
      r_gnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      rsp_id   <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_gnt <= w_onehot;
          r_win <= w_win;
          r_op  <= w_sel_op;
          r_a   <= w_sel_a;
          r_b   <= w_sel_b;
        end
        ST_EXEC: begin
          rsp_data <= w_data;
          rsp_err  <= w_err;
          rsp_id   <= r_win;
        end
        ST_RESP: if (rsp_ready) begin
          r_ptr <= (r_win == IDW'(NREQ - 1)) ? '0 : r_win + IDW'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = (r_state == ST_RESP);

  logic_unit_core #(.W(W)) u_core (
    .op   (r_op),
    .a    (r_a),
    .b    (r_b),
    .data (w_data),
    .err  (w_err)
  );

`ifdef LOGIC_ARB_CNT_EN
  logic [CNT_W-1:0] r_cnt [NREQ];

  // NOTE: the counter array is a handful of flops, not a RAM, so resetting it is cheap and required.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_gnt[i] && (r_cnt[i] != {CNT_W{1'b1}})) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    gnt_cnt = '0;
    for (int i = 0; i < NREQ; i++) gnt_cnt[CNT_W*i +: CNT_W] = r_cnt[i];
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (define LOGIC_ARB_CNT_EN to cover gnt_cnt).
module tb_logic_unit_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req;
  logic [3*NREQ-1:0]       op;
  logic [W*NREQ-1:0]       a, b;
  logic [NREQ-1:0]         gnt;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [W-1:0]            rsp_data;
  logic                    rsp_err;
`ifdef LOGIC_ARB_CNT_EN
  logic [8*NREQ-1:0]       gnt_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
`ifdef LOGIC_ARB_CNT_EN
    ,
    .gnt_cnt   (gnt_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_gnt(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (gnt != '0) break;
    end
  endtask

  // Issue one operation on requester idx from IDLE and check grant and response.
  task automatic run_op(input string tag, input int idx, input logic [2:0] opc,
                        input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_d, input logic exp_e);
    op[3*idx +: 3] = opc;
    a[8*idx +: 8]  = av;
    b[8*idx +: 8]  = bv;
    req[idx]       = 1'b1;
    wait_gnt(8);
    check({tag, "_gnt"}, 32'(gnt), 32'(1) << idx);
    check({tag, "_valid_exec"}, 32'(rsp_valid), 32'd0);
    req[idx] = 1'b0;
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},    32'(rsp_id),    32'(idx));
    check({tag, "_data"},  32'(rsp_data),  32'(exp_d));
    check({tag, "_err"},   32'(rsp_err),   32'(exp_e));
    check({tag, "_gnt_off"}, 32'(gnt), 32'd0);
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int last;
    logic [7:0] av;
    rst_n = 1'b0; req = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b1;
    tick(); tick();
    check("rst_gnt",   32'(gnt),       32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data",  32'(rsp_data),  32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    check("rst_err",   32'(rsp_err),   32'd0);
`ifdef LOGIC_ARB_CNT_EN
    check("rst_cnt",   gnt_cnt,        32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic AND on requester 0, then every opcode with hand-computed results.
    run_op("and0",  0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
    run_op("nand1", 1, 3'd1, 8'hF0, 8'h3C, 8'hCF, 1'b0);
    run_op("or3",   3, 3'd2, 8'hF0, 8'h3C, 8'hFC, 1'b0);
    run_op("nor0",  0, 3'd3, 8'hF0, 8'h3C, 8'h03, 1'b0);
    run_op("xor1",  1, 3'd5, 8'hF0, 8'h3C, 8'hCC, 1'b0);
    run_op("xnor3", 3, 3'd6, 8'hF0, 8'h3C, 8'h33, 1'b0);
    run_op("nota2", 2, 3'd4, 8'hA5, 8'h3C, 8'h5A, 1'b0);
    run_op("ill2",  2, 3'd7, 8'hA5, 8'h3C, 8'h00, 1'b1);
    run_op("andff", 0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0);

    // Back-pressure: response held for 5 cycles while requester 1 waits.
    rsp_ready = 1'b0;
    op[2:0] = 3'd0; a[7:0] = 8'hF0; b[7:0] = 8'h3C;
    req = 4'b0001;
    wait_gnt(8);
    check("bp_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    check("bp_valid0", 32'(rsp_valid), 32'd1);
    op[5:3] = 3'd2; a[15:8] = 8'h0F; b[15:8] = 8'h30;
    req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data",  32'(rsp_data),  32'h30);
      check("bp_id",    32'(rsp_id),    32'd0);
      check("bp_err",   32'(rsp_err),   32'd0);
      check("bp_nognt", 32'(gnt),       32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_idle_valid", 32'(rsp_valid), 32'd0);
    check("bp_idle_gnt",   32'(gnt),       32'd0);
    tick();
    check("bp_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    check("bp_data1", 32'(rsp_data), 32'h3F);
    check("bp_id1",   32'(rsp_id),   32'd1);
    tick();

    // Reset during EXEC: pointer (now 2) must return to 0.
    op[8:6] = 3'd5; a[23:16] = 8'h55; b[23:16] = 8'hFF;
    req = 4'b0100;
    wait_gnt(8);
    check("rx_gnt", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    check("rx_gnt_clr", 32'(gnt),       32'd0);
    check("rx_valid",   32'(rsp_valid), 32'd0);
    req = 4'b0110;
    tick();
    check("rx_valid_hold", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rx_first_gnt", 32'(gnt),       32'h2);
    check("rx_no_valid",  32'(rsp_valid), 32'd0);
    req = 4'b0000;
    tick();
    check("rx_id",   32'(rsp_id),   32'd1);
    check("rx_data", 32'(rsp_data), 32'h3F);
    tick();

    // All four requesting: grants rotate 0,1,2,3,0 three cycles apart.
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      av = 8'(8'h11 * (i + 1));
      op[3*i +: 3] = 3'd5;
      a[8*i +: 8]  = av;
      b[8*i +: 8]  = 8'hFF;
    end
    req  = 4'b1111;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(6);
      check("rr_gnt", 32'(gnt), 32'(1) << (g % NREQ));
      if (g > 0) check("rr_gap", 32'(cyc - last), 32'd3);
      last = cyc;
      tick();
      check("rr_id",   32'(rsp_id),   32'(g % NREQ));
      check("rr_data", 32'(rsp_data), 32'(8'(~(8'h11 * ((g % NREQ) + 1)))));
    end
    req = 4'b0000;
    tick();

`ifdef LOGIC_ARB_CNT_EN
    begin
      int n_g;
      pulse_reset();
      n_g = 0;
      req = 4'b0001;
      for (int i = 0; i < 1200; i++) begin
        tick();
        if (gnt[0]) n_g++;
        if (n_g == 300) break;
      end
      req = 4'b0000;
      check("cnt_grants", 32'(n_g), 32'd300);
      tick(); tick();
      check("cnt_sat", gnt_cnt, 32'h0000_00FF);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, operand/result width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester request; held until its gnt bit is seen.
REQ-006 op  input  3*NREQ  per-requester opcode, slice i = op[3i+2:3i].
REQ-007 a  input  W*NREQ  per-requester operand A, slice i = a[Wi+W-1:Wi].
REQ-008 b  input  W*NREQ  per-requester operand B, same slicing.
REQ-009 gnt  output  NREQ  one-hot grant pulse, registered.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  clog2(NREQ)  index of the granted requester.
REQ-013 rsp_data  output  W  bitwise result.
REQ-014 rsp_err  output  1  illegal opcode flag.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC when any req bit is 1; EXEC->RESP unconditionally; RESP->IDLE when rsp_ready=1.
REQ-016 In IDLE, the winner SHALL be the first set req bit at or above the round-robin pointer, wrapping from NREQ-1 to 0.
REQ-017 On the IDLE->EXEC edge the winner's op, a, b SHALL be latched, and gnt[winner] SHALL be 1 for exactly the EXEC cycle.
REQ-018 Opcodes SHALL be 0 AND, 1 NAND, 2 OR, 3 NOR, 4 NOT A (B ignored), 5 XOR, 6 XNOR, applied bitwise over W bits.
REQ-019 Opcode 7 SHALL give rsp_data=0 and rsp_err=1; legal opcodes SHALL give rsp_err=0.
REQ-020 On the EXEC->RESP edge rsp_data, rsp_err, rsp_id SHALL be registered; rsp_valid SHALL be 1 throughout RESP and 0 otherwise.
REQ-021 Latency SHALL be 2 cycles from the edge sampling req in IDLE to rsp_valid=1; rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-022 On the RESP->IDLE edge the pointer SHALL become (winner+1) mod NREQ; a req still high in that IDLE cycle SHALL be arbitrated normally (no bubble beyond IDLE).
REQ-023 Requests arriving during EXEC/RESP SHALL be ignored until IDLE; no request is lost while its req stays high.
REQ-024 Throughput SHALL be at most one operation per 3 cycles with rsp_ready tied high.

Reset
REQ-025 rst_n=0 SHALL force, asynchronously: state IDLE, pointer 0, gnt 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, and (when enabled) all counters 0.
REQ-026 Reset mid-operation SHALL discard the in-flight operation without a response; the first cycle after release SHALL be IDLE.

Configuration
REQ-027 Macro LOGIC_ARB_CNT_EN defined: output gnt_cnt (8*NREQ) SHALL hold per-requester 8-bit saturating grant counts, incremented on each gnt pulse, sticking at 255.
REQ-028 Macro undefined: gnt_cnt port and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package logic_unit_pkg SHALL hold the 3-bit opcode enum (OP_AND..OP_XNOR, OP_ILL=7) and the FSM state typedef.
REQ-030 The bitwise datapath SHALL be a separate combinational sub-module logic_unit_core (op, a, b -> data, err), instantiated once.

Verification
REQ-031 W=8, req=0001, op0=0, a0=0xF0, b0=0x3C, rsp_ready=1 -> gnt=0001 one cycle, then rsp_valid=1, rsp_id=0, rsp_data=0x30, rsp_err=0.
REQ-032 All four req high and held, rsp_ready=1 -> grant order 0,1,2,3,0; gnt pulses 3 cycles apart.
REQ-033 Requester 2: op=4, a=0xA5 -> rsp_data=0x5A; op=7 -> rsp_data=0x00, rsp_err=1.
REQ-034 rsp_ready=0 for 5 cycles in RESP, req1 raised meanwhile -> rsp_* stable, no gnt until one IDLE cycle after the handshake.
REQ-035 rst_n low during EXEC -> rsp_valid stays 0, pointer back to 0, next grant goes to the lowest set req.
REQ-036 LOGIC_ARB_CNT_EN defined, 300 grants to requester 0 -> gnt_cnt slice 0 = 255, other slices 0.
